// File: rtl/seq_stream_controller.sv
// Stream controller for the serial sequence detector: resets the detector, shifts a
// latched pattern into its X input MSB-first, and tallies detector hits for the run.
module seq_stream_controller #(
    parameter int unsigned PAT_W = 48,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic             z_lag,
    input  logic [CNT_W-1:0] len,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             det_z,
    output logic             det_reset,
    output logic             det_x,
    output logic             det_m,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] first_hit,
    output logic             first_valid
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(PAT_W);

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic               zlag_q, zlag_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               det_reset_d, det_x_d, det_m_d, busy_d, done_d;
    logic [CNT_W-1:0]   hit_d, first_d;
    logic               fv_d;

    logic [CNT_W-1:0]   len_eff_c;
    logic               last_c;
    logic               sample_c;
    logic [CNT_W-1:0]   sidx_c;

    // Zero or over-long requests stream the full pattern width
    assign len_eff_c = ((len == '0) || (len > LEN_MAX)) ? LEN_MAX : len;
    assign last_c    = (idx_q == (len_q - CNT_W'(1)));
    assign sample_c  = ((state_q == STREAM) && (idx_q >= CNT_W'(zlag_q))) || (state_q == DRAIN);
    assign sidx_c    = (state_q == DRAIN) ? (len_q - CNT_W'(1)) : (idx_q - CNT_W'(zlag_q));

    // Outputs are registered from the next state, so each reflects the state it is in
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        len_d       = len_q;
        zlag_d      = zlag_q;
        idx_d       = idx_q;
        det_m_d     = det_m;
        hit_d       = hit_count;
        first_d     = first_hit;
        fv_d        = first_valid;
        det_reset_d = 1'b0;
        det_x_d     = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        if (sample_c && det_z) begin
            if (hit_count != CNT_MAX) begin
                hit_d = hit_count + CNT_W'(1);
            end
            if (!first_valid) begin
                first_d = sidx_c;
                fv_d    = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    pat_d       = pat_in;
                    len_d       = len_eff_c;
                    zlag_d      = z_lag;
                    det_m_d     = mode;
                    idx_d       = '0;
                    hit_d       = '0;
                    first_d     = '0;
                    fv_d        = 1'b0;
                    state_d     = CLEAR;
                    det_reset_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            CLEAR: begin
                state_d = STREAM;
                idx_d   = '0;
                det_x_d = pat_q[PAT_W-1];
                pat_d   = pat_q << 1;
                busy_d  = 1'b1;
            end
            STREAM: begin
                idx_d = idx_q + CNT_W'(1);
                if (last_c) begin
                    if (zlag_q) begin
                        state_d = DRAIN;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    det_x_d = pat_q[PAT_W-1];
                    pat_d   = pat_q << 1;
                    busy_d  = 1'b1;
                end
            end
            DRAIN: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over everything; partial results stay visible
        if (abort) begin
            state_d     = IDLE;
            det_x_d     = 1'b0;
            det_reset_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            zlag_q      <= 1'b0;
            idx_q       <= '0;
            det_reset   <= 1'b1;
            det_x       <= 1'b0;
            det_m       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hit_count   <= '0;
            first_hit   <= '0;
            first_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            zlag_q      <= zlag_d;
            idx_q       <= idx_d;
            det_reset   <= det_reset_d;
            det_x       <= det_x_d;
            det_m       <= det_m_d;
            busy        <= busy_d;
            done        <= done_d;
            hit_count   <= hit_d;
            first_hit   <= first_d;
            first_valid <= fv_d;
        end
    end

endmodule

// File: tb/tb_seq_stream_controller.sv
// Directed bench for seq_stream_controller with a small in-bench detector stand-in.
module tb_seq_stream_controller;

    localparam int unsigned PAT_W = 48;
    localparam int unsigned CNT_W = 6;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             mode = 1'b0;
    logic             z_lag = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic [PAT_W-1:0] pat_in = '0;
    logic             det_z;
    logic             det_reset, det_x, det_m, busy, done, first_valid;
    logic [CNT_W-1:0] hit_count, first_hit;

    // zsel: 0 tie low, 1 tie high, 2 det_z=det_x, 3 det_z=det_x one cycle late
    int               zsel = 0;
    logic             xdly = 1'b0;
    int               vectors = 0;
    int               miscompares = 0;

    seq_stream_controller #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .z_lag(z_lag), .len(len), .pat_in(pat_in), .det_z(det_z),
        .det_reset(det_reset), .det_x(det_x), .det_m(det_m), .busy(busy),
        .done(done), .hit_count(hit_count), .first_hit(first_hit),
        .first_valid(first_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) xdly <= det_x;

    always_comb begin
        case (zsel)
            1:       det_z = 1'b1;
            2:       det_z = det_x;
            3:       det_z = xdly;
            default: det_z = 1'b0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges (including the first) until done is seen; -1 on timeout
    task automatic wait_done(output int n);
        n = -1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (done) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        vectors++; if (det_reset !== 1'b1) begin miscompares++; $display("FAIL rst_det_reset: got %b want 1", det_reset); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (det_x !== 1'b0 || det_m !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL rst_outs: got x=%b m=%b done=%b want 0", det_x, det_m, done); end
        vectors++; if (hit_count !== 0 || first_hit !== 0 || first_valid !== 1'b0) begin miscompares++; $display("FAIL rst_results: got %0d/%0d/%b want 0", hit_count, first_hit, first_valid); end
        #10 reset = 1'b1;
        tick();
        vectors++; if (det_reset !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_idle: got det_reset=%b busy=%b want 0/0", det_reset, busy); end
    endtask

    task automatic test_basic();
        logic [3:0] exp_bits;
        exp_bits = 4'b1011;
        zsel = 2; z_lag = 1'b0; len = 6'd4; mode = 1'b1;
        pat_in = {4'b1011, 44'h0};
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++; if (det_reset !== 1'b1 || det_x !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL basic_clear: got rst=%b x=%b busy=%b want 1/0/1", det_reset, det_x, busy); end
        vectors++; if (det_m !== 1'b1) begin miscompares++; $display("FAIL basic_mode: got %b want 1", det_m); end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if (det_x !== exp_bits[3-i] || det_reset !== 1'b0) begin miscompares++; $display("FAIL basic_bit%0d: got x=%b rst=%b want %b/0", i, det_x, det_reset, exp_bits[3-i]); end
        end
        tick();
        vectors++; if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL basic_done6: got done=%b busy=%b want 1/0", done, busy); end
        vectors++; if (hit_count !== 6'd3 || first_hit !== 6'd0 || first_valid !== 1'b1) begin miscompares++; $display("FAIL basic_results: got %0d/%0d/%b want 3/0/1", hit_count, first_hit, first_valid); end
        tick();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_z_lag();
        int n;
        zsel = 3; z_lag = 1'b1; len = 6'd4; mode = 1'b0;
        pat_in = {4'b1011, 44'h0};
        start = 1'b1;
        wait_done(n);
        start = 1'b0;
        vectors++; if (n !== 7) begin miscompares++; $display("FAIL lag_latency: got %0d want 7", n); end
        vectors++; if (hit_count !== 6'd3 || first_hit !== 6'd0 || first_valid !== 1'b1) begin miscompares++; $display("FAIL lag_results: got %0d/%0d/%b want 3/0/1", hit_count, first_hit, first_valid); end
        tick();
        // Only the last bit is set, so the sole hit lands in the drain cycle
        pat_in = {4'b0001, 44'h0};
        start = 1'b1;
        wait_done(n);
        start = 1'b0;
        vectors++; if (hit_count !== 6'd1 || first_hit !== 6'd3 || first_valid !== 1'b1) begin miscompares++; $display("FAIL lag_drain: got %0d/%0d/%b want 1/3/1", hit_count, first_hit, first_valid); end
        tick();
    endtask

    task automatic test_full_pattern();
        logic [PAT_W-1:0] pat;
        int bad;
        pat = 48'b010101101011000110101101011011101001011001011011;
        zsel = 0; z_lag = 1'b0; len = 6'd0; mode = 1'b0;
        pat_in = pat;
        start = 1'b1;
        tick();
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < 48; i++) begin
            tick();
            if (det_x !== pat[47-i] || busy !== 1'b1) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL full_stream: got %0d bad bits want 0", bad); end
        tick();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL full_done: got %b want 1", done); end
        vectors++; if (hit_count !== 6'd0 || first_valid !== 1'b0) begin miscompares++; $display("FAIL full_results: got %0d/%b want 0/0", hit_count, first_valid); end
        tick();
    endtask

    task automatic test_all_hits();
        int dcount, dedge;
        zsel = 1; z_lag = 1'b0; len = 6'd0; mode = 1'b1;
        pat_in = 48'h0;
        dcount = 0; dedge = 0;
        start = 1'b1;
        tick();
        for (int k = 2; k <= 60; k++) begin
            start = (k == 20);
            tick();
            if (done) begin dcount++; dedge = k; end
        end
        start = 1'b0;
        vectors++; if (dcount !== 1 || dedge !== 50) begin miscompares++; $display("FAIL ones_done: got %0d pulses at edge %0d want 1 at 50", dcount, dedge); end
        vectors++; if (hit_count !== 6'd48 || first_hit !== 6'd0 || first_valid !== 1'b1) begin miscompares++; $display("FAIL ones_results: got %0d/%0d/%b want 48/0/1", hit_count, first_hit, first_valid); end
        vectors++; if (det_m !== 1'b1) begin miscompares++; $display("FAIL ones_mode: got %b want 1", det_m); end
    endtask

    task automatic test_abort();
        int dcount, n;
        zsel = 2; z_lag = 1'b0; len = 6'd0; mode = 1'b0;
        pat_in = {11'b11010001010, 37'h0};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++; if (busy !== 1'b0 || det_x !== 1'b0 || done !== 1'b0 || det_reset !== 1'b0) begin miscompares++; $display("FAIL abort_idle: got busy=%b x=%b done=%b rst=%b want 0", busy, det_x, done, det_reset); end
        vectors++; if (hit_count !== 6'd5 || first_hit !== 6'd0 || first_valid !== 1'b1) begin miscompares++; $display("FAIL abort_partial: got %0d/%0d/%b want 5/0/1", hit_count, first_hit, first_valid); end
        dcount = 0;
        for (int i = 0; i < 60; i++) begin tick(); if (done || busy) dcount++; end
        vectors++; if (dcount !== 0) begin miscompares++; $display("FAIL abort_no_done: got %0d active cycles want 0", dcount); end
        // Start blocked by a simultaneous abort
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        vectors++; if (busy !== 1'b0 || det_reset !== 1'b0 || hit_count !== 6'd5) begin miscompares++; $display("FAIL abort_start: got busy=%b rst=%b hits=%0d want 0/0/5", busy, det_reset, hit_count); end
        len = 6'd4;
        pat_in = {4'b1011, 44'h0};
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++; if (hit_count !== 6'd0 || first_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL abort_restart_clear: got %0d/%b busy=%b want 0/0/1", hit_count, first_valid, busy); end
        wait_done(n);
        vectors++; if (n !== 5 || hit_count !== 6'd3) begin miscompares++; $display("FAIL abort_restart_run: got edges=%0d hits=%0d want 5/3", n, hit_count); end
        tick();
    endtask

    task automatic test_reset_mid_stream();
        zsel = 1; z_lag = 1'b0; len = 6'd0;
        pat_in = {PAT_W{1'b1}};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        #1;
        vectors++; if (det_reset !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_async: got rst=%b busy=%b want 1/0", det_reset, busy); end
        vectors++; if (det_x !== 1'b0 || hit_count !== 6'd0) begin miscompares++; $display("FAIL mid_rst_clear: got x=%b hits=%0d want 0/0", det_x, hit_count); end
        #2 reset = 1'b1;
        tick();
        tick();
        vectors++; if (busy !== 1'b0 || det_reset !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL mid_rst_idle: got busy=%b rst=%b done=%b want 0/0/0", busy, det_reset, done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_z_lag();
        test_full_pattern();
        test_all_hits();
        test_abort();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
